// File: rtl/posit_decode_arbiter.sv
// Round-robin front end sharing one 64-bit posit decoder among NREQ requesters.
// Two registered stages (operand, result) with full backpressure; each result
// carries the tag of its requester.
//   clk, rst_n        clock, async active-low reset
//   flush             synchronous pipeline clear (priority over accept/load)
//   req_valid/ready   per-requester handshake, req_data packed N bits each
//   out_valid/ready   result handshake; out_tag + decoded fields
//   busy              any stage occupied

module lzd_64_4_decoder (
  input  logic [63:0] in,
  output logic        sign,
  output logic [6:0]  regi,
  output logic [3:0]  expo,
  output logic [56:0] frac,
  output logic        inf,
  output logic        allzero,
  output logic        allone
);

  logic [62:0] rem;
  logic [62:0] diff;
  logic [6:0]  run;
  logic        found;
  logic [60:0] body;

  always_comb begin
    sign    = in[63];
    // Magnitude only needs the low 63 bits of the two's complement.
    rem     = in[63] ? (~in[62:0] + 63'd1) : in[62:0];
    diff    = rem ^ {63{rem[62]}};
    run     = 7'd63;
    found   = 1'b0;
    for (int unsigned i = 0; i < 63; i++) begin
      if (!found && diff[6'(62 - i)]) begin
        run   = 7'(i);
        found = 1'b1;
      end
    end
    regi    = rem[62] ? (run - 7'd1) : (7'd0 - run);
    // Skipping regime run plus terminator; the two guaranteed leading bits are
    // dropped up front so the shift never needs the unused low bits.
    body    = rem[60:0] << (run - 7'd1);
    expo    = body[60:57];
    frac    = body[56:0];
    inf     = (in == {1'b1, 63'd0});
    allzero = (in == '0);
    allone  = &in;
  end

endmodule

module posit_decode_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned TW   = 2,
  parameter int unsigned N    = 64,
  parameter int unsigned ES   = 4,
  parameter int unsigned FS   = 57
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TW-1:0]     out_tag,
  output logic              out_sign,
  output logic [6:0]        out_regi,
  output logic [ES-1:0]     out_expo,
  output logic [FS-1:0]     out_frac,
  output logic              out_inf,
  output logic              out_allzero,
  output logic              out_allone,
  output logic              busy
);

  logic            s1_valid_q, s1_valid_d;
  logic [N-1:0]    s1_data_q, s1_data_d;
  logic [TW-1:0]   s1_tag_q, s1_tag_d;
  logic [TW-1:0]   rr_ptr_q, rr_ptr_d;

  logic            out_valid_q, out_valid_d;
  logic [TW-1:0]   out_tag_q, out_tag_d;
  logic            out_sign_q, out_sign_d;
  logic [6:0]      out_regi_q, out_regi_d;
  logic [ES-1:0]   out_expo_q, out_expo_d;
  logic [FS-1:0]   out_frac_q, out_frac_d;
  logic            out_inf_q, out_inf_d;
  logic            out_allzero_q, out_allzero_d;
  logic            out_allone_q, out_allone_d;

  logic            dec_sign, dec_inf, dec_allzero, dec_allone;
  logic [6:0]      dec_regi;
  logic [ES-1:0]   dec_expo;
  logic [FS-1:0]   dec_frac;

  logic            s2_load, s1_free, accept;
  logic            win_found;
  logic [TW-1:0]   win_idx, cand;
  logic [N-1:0]    win_data;
  logic [NREQ-1:0] grant;

  lzd_64_4_decoder u_dec (
    .in      (s1_data_q),
    .sign    (dec_sign),
    .regi    (dec_regi),
    .expo    (dec_expo),
    .frac    (dec_frac),
    .inf     (dec_inf),
    .allzero (dec_allzero),
    .allone  (dec_allone)
  );

  always_comb begin
    s2_load = s1_valid_q & (~out_valid_q | out_ready);
    s1_free = ~s1_valid_q | s2_load;
  end

  // Round-robin search starting at rr_ptr, wrapping modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = TW'((32'(rr_ptr_q) + off) % NREQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (TW'(i) == win_idx) begin
        win_data = req_data[i*N +: N];
      end
    end
  end

  // rst_n gates the grant so nothing is offered while reset is held.
  always_comb begin
    grant = '0;
    if (win_found && s1_free && !flush && rst_n) begin
      grant[win_idx] = 1'b1;
    end
    accept = |grant;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_tag_d   = s1_tag_q;
    rr_ptr_d   = rr_ptr_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (accept) begin
      s1_valid_d = 1'b1;
      s1_data_d  = win_data;
      s1_tag_d   = win_idx;
      rr_ptr_d   = (win_idx == TW'(NREQ - 1)) ? '0 : win_idx + TW'(1);
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_tag_d     = out_tag_q;
    out_sign_d    = out_sign_q;
    out_regi_d    = out_regi_q;
    out_expo_d    = out_expo_q;
    out_frac_d    = out_frac_q;
    out_inf_d     = out_inf_q;
    out_allzero_d = out_allzero_q;
    out_allone_d  = out_allone_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (s2_load) begin
      out_valid_d   = 1'b1;
      out_tag_d     = s1_tag_q;
      out_sign_d    = dec_sign;
      out_regi_d    = dec_regi;
      out_expo_d    = dec_expo;
      out_frac_d    = dec_frac;
      out_inf_d     = dec_inf;
      out_allzero_d = dec_allzero;
      out_allone_d  = dec_allone;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_data_q     <= '0;
      s1_tag_q      <= '0;
      rr_ptr_q      <= '0;
      out_valid_q   <= 1'b0;
      out_tag_q     <= '0;
      out_sign_q    <= 1'b0;
      out_regi_q    <= '0;
      out_expo_q    <= '0;
      out_frac_q    <= '0;
      out_inf_q     <= 1'b0;
      out_allzero_q <= 1'b0;
      out_allone_q  <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_data_q     <= s1_data_d;
      s1_tag_q      <= s1_tag_d;
      rr_ptr_q      <= rr_ptr_d;
      out_valid_q   <= out_valid_d;
      out_tag_q     <= out_tag_d;
      out_sign_q    <= out_sign_d;
      out_regi_q    <= out_regi_d;
      out_expo_q    <= out_expo_d;
      out_frac_q    <= out_frac_d;
      out_inf_q     <= out_inf_d;
      out_allzero_q <= out_allzero_d;
      out_allone_q  <= out_allone_d;
    end
  end

  always_comb begin
    req_ready   = grant;
    out_valid   = out_valid_q;
    out_tag     = out_tag_q;
    out_sign    = out_sign_q;
    out_regi    = out_regi_q;
    out_expo    = out_expo_q;
    out_frac    = out_frac_q;
    out_inf     = out_inf_q;
    out_allzero = out_allzero_q;
    out_allone  = out_allone_q;
    busy        = s1_valid_q | out_valid_q;
  end

endmodule

// File: tb/tb_posit_decode_arbiter.sv
module tb_posit_decode_arbiter;

  typedef struct packed {
    logic        sign;
    logic [6:0]  regi;
    logic [3:0]  expo;
    logic [56:0] frac;
    logic        inf;
    logic        zero;
    logic        one;
  } dec_t;

  typedef struct packed {
    logic [1:0]  tag;
    logic [63:0] data;
  } sb_t;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic [3:0]   req_valid;
  logic [255:0] req_data;
  logic [3:0]   req_ready;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_tag;
  logic         out_sign;
  logic [6:0]   out_regi;
  logic [3:0]   out_expo;
  logic [56:0]  out_frac;
  logic         out_inf;
  logic         out_allzero;
  logic         out_allone;
  logic         busy;

  logic [63:0]  opnd [4];
  assign req_data = {opnd[3], opnd[2], opnd[1], opnd[0]};

  int   vectors;
  int   miscompares;
  sb_t  sb [$];
  logic m_s1v;
  logic m_ov;
  int   m_rr;
  logic one_shot;

  posit_decode_arbiter #(.NREQ(4), .TW(2), .N(64), .ES(4), .FS(57)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_tag     (out_tag),
    .out_sign    (out_sign),
    .out_regi    (out_regi),
    .out_expo    (out_expo),
    .out_frac    (out_frac),
    .out_inf     (out_inf),
    .out_allzero (out_allzero),
    .out_allone  (out_allone),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bit-serial reference decode: walk the regime run, then pick exponent and
  // fraction bits one at a time after the terminator.
  function automatic dec_t model_dec(input logic [63:0] x);
    dec_t        d;
    logic [63:0] a;
    logic        r0;
    int          run;
    int          pos;
    d      = '0;
    d.sign = x[63];
    a      = x[63] ? (~x + 64'd1) : x;
    d.inf  = (x == 64'h8000_0000_0000_0000);
    d.zero = (x == 64'd0);
    d.one  = (x == 64'hFFFF_FFFF_FFFF_FFFF);
    r0     = a[62];
    run    = 0;
    for (int i = 62; i >= 0; i--) begin
      if (a[i] != r0) break;
      run++;
    end
    d.regi = r0 ? 7'(run - 1) : 7'(-run);
    pos    = 61 - run;
    for (int j = 0; j < 4; j++)
      d.expo[3-j] = (pos - j >= 0) ? a[pos-j] : 1'b0;
    for (int j = 0; j < 57; j++)
      d.frac[56-j] = (pos - 4 - j >= 0) ? a[pos-4-j] : 1'b0;
    return d;
  endfunction

  function automatic int find_win(input logic [3:0] v, input int rr);
    for (int off = 0; off < 4; off++) begin
      int idx;
      idx = (rr + off) % 4;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy",      64'(busy), 64'd0);
    chk("rst_tag",       64'(out_tag), 64'd0);
    chk("rst_sign",      64'(out_sign), 64'd0);
    chk("rst_regi",      64'(out_regi), 64'd0);
    chk("rst_expo",      64'(out_expo), 64'd0);
    chk("rst_frac",      64'(out_frac), 64'd0);
    chk("rst_inf",       64'(out_inf), 64'd0);
    chk("rst_allzero",   64'(out_allzero), 64'd0);
    chk("rst_allone",    64'(out_allone), 64'd0);
  endtask

  // One clock: check combinational grant and the registered output against
  // the model, then advance the model across the edge.
  task automatic step();
    int         w;
    logic [3:0] exp_rdy;
    logic       s2l, s1f, got;
    dec_t       d;
    #3;
    s2l     = m_s1v && (!m_ov || out_ready);
    s1f     = !m_s1v || s2l;
    w       = find_win(req_valid, m_rr);
    exp_rdy = '0;
    got     = (w >= 0) && s1f && !flush;
    if (got) exp_rdy[w[1:0]] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("busy",      64'(busy), 64'(m_s1v | m_ov));
    if (m_ov) begin
      if (sb.size() == 0) begin
        miscompares++;
        $error("FAIL scoreboard: observed empty expected entry");
      end else begin
        d = model_dec(sb[0].data);
        chk("out_tag",     64'(out_tag), 64'(sb[0].tag));
        chk("out_sign",    64'(out_sign), 64'(d.sign));
        chk("out_regi",    64'(out_regi), 64'(d.regi));
        chk("out_expo",    64'(out_expo), 64'(d.expo));
        chk("out_frac",    64'(out_frac), 64'(d.frac));
        chk("out_inf",     64'(out_inf), 64'(d.inf));
        chk("out_allzero", 64'(out_allzero), 64'(d.zero));
        chk("out_allone",  64'(out_allone), 64'(d.one));
        if (out_ready) void'(sb.pop_front());
      end
    end
    if (flush) begin
      m_s1v = 1'b0;
      m_ov  = 1'b0;
      sb.delete();
    end else begin
      if (s2l) m_ov = 1'b1;
      else if (out_ready) m_ov = 1'b0;
      if (got) begin
        sb.push_back('{tag: w[1:0], data: opnd[w[1:0]]});
        m_s1v = 1'b1;
        m_rr  = (w + 1) % 4;
      end else if (s2l) begin
        m_s1v = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (got) begin
      opnd[w[1:0]] = {$urandom, $urandom};
      if (one_shot) req_valid[w[1:0]] = 1'b0;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_s1v       = 1'b0;
    m_ov        = 1'b0;
    m_rr        = 0;
    one_shot    = 1'b1;
    rst_n       = 1'b1;
    flush       = 1'b0;
    out_ready   = 1'b0;
    req_valid   = 4'b0000;
    for (int i = 0; i < 4; i++) opnd[i] = {$urandom, $urandom};

    // Reset with requests already asserted: nothing granted.
    #1 rst_n = 1'b0;
    req_valid = 4'b1111;
    #1 chk_reset_state();
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'b0000;
    rst_n     = 1'b1;
    step();

    // Single zero operand from requester 0.
    opnd[0]   = 64'd0;
    req_valid = 4'b0001;
    out_ready = 1'b1;
    repeat (4) step();

    // All requesting, boundary operands, grants rotate with no bubbles.
    opnd[0]   = 64'hFFFF_FFFF_FFFF_FFFF;
    opnd[1]   = 64'h4000_0000_0000_0000;
    opnd[2]   = 64'h0000_0000_0000_0001;
    opnd[3]   = 64'h7FFF_FFFF_FFFF_FFFF;
    one_shot  = 1'b0;
    req_valid = 4'b1111;
    repeat (8) step();
    one_shot  = 1'b1;
    repeat (7) step();

    // NaR from requester 2.
    opnd[2]   = 64'h8000_0000_0000_0000;
    req_valid = 4'b0100;
    repeat (4) step();

    // Backpressure: two accepts fill both stages, then grants stop.
    one_shot  = 1'b0;
    out_ready = 1'b0;
    req_valid = 4'b1111;
    repeat (5) step();
    out_ready = 1'b1;
    repeat (3) step();
    one_shot  = 1'b1;
    repeat (8) step();

    // Flush with both stages full and requests pending.
    one_shot  = 1'b0;
    out_ready = 1'b0;
    req_valid = 4'b1111;
    repeat (3) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    one_shot  = 1'b1;
    out_ready = 1'b1;
    repeat (8) step();

    // Asynchronous reset mid-stream.
    one_shot  = 1'b0;
    req_valid = 4'b1111;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1 chk_reset_state();
    m_s1v = 1'b0;
    m_ov  = 1'b0;
    m_rr  = 0;
    sb.delete();
    @(posedge clk);
    #1;
    req_valid = 4'b1010;
    rst_n     = 1'b1;
    one_shot  = 1'b1;
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
